// File: rtl/edge_loader_pkg.sv
// -----------------------------------------------------------------------------
// edge_loader_pkg
//   Shared definitions for the edge cache writer front end.
//   - Default geometry of the loadable graph (node count, index and weight
//     widths).
//   - Loader state encoding.
//   - Address-packing helper for the {to_node, from_node} edge address. The
//     edge cache packs its addresses the same way.
// -----------------------------------------------------------------------------
package edge_loader_pkg;

    localparam int DEFAULT_MAX_NODES   = 64;
    localparam int DEFAULT_INDEX_WIDTH = 6;
    localparam int DEFAULT_VALUE_WIDTH = 32;

    typedef enum logic [0:0] {
        LOADER_IDLE = 1'b0,
        LOADER_LOAD = 1'b1
    } loader_state_t;

    // Pack two node indices of the default width into one edge address.
    // The destination node sits in the upper half and the source node in
    // the lower half, matching the edge cache's row layout.
    function automatic logic [2*DEFAULT_INDEX_WIDTH-1:0] pack_edge_address(
        input logic [DEFAULT_INDEX_WIDTH-1:0] to_node,
        input logic [DEFAULT_INDEX_WIDTH-1:0] from_node
    );
        return {to_node, from_node};
    endfunction

endpackage

// File: rtl/edge_index_counter.sv
// -----------------------------------------------------------------------------
// edge_index_counter
//   Two-dimensional row/col index counter with a run-time limit n.
//   col is the inner index and row the outer index; both run 0..n-1.
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous, active-high
//   clear    in   return both indices to 0 (has priority over advance)
//   advance  in   step to the next (row, col) position
//   n        in   limit, INDEX_WIDTH+1 bits, must be >= 1 while advancing
//   row      out  outer index
//   col      out  inner index
//   last     out  high while (row, col) == (n-1, n-1)
// -----------------------------------------------------------------------------
module edge_index_counter #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [INDEX_WIDTH:0]   n,
    output logic [INDEX_WIDTH-1:0] row,
    output logic [INDEX_WIDTH-1:0] col,
    output logic                   last
);

    logic [INDEX_WIDTH:0] limit;
    logic                 col_at_end;
    logic                 row_at_end;

    // Compare in INDEX_WIDTH+1 bits against n-1 so that n == 2**INDEX_WIDTH
    // needs no wider counters.
    assign limit      = n - {{INDEX_WIDTH{1'b0}}, 1'b1};
    assign col_at_end = ({1'b0, col} == limit);
    assign row_at_end = ({1'b0, row} == limit);
    assign last       = col_at_end & row_at_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_at_end) begin
                col <= '0;
                // After the final position both indices return to 0 rather
                // than letting row run past n-1.
                row <= row_at_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_loader.sv
// -----------------------------------------------------------------------------
// edge_loader
//   Writer-side front end for the edge cache. Takes a row-major stream of
//   edge weights (from_node outer, to_node inner) and turns every accepted
//   word into a single-cycle write strobe at {to_node, from_node}.
//
// Ports
//   clock             in   system clock, rising edge
//   reset             in   asynchronous, active-high
//   start             in   one-cycle load request
//   abort             in   synchronous cancel of the current load
//   num_nodes         in   node count n, sampled on an accepted start
//   in_valid          in   stream word valid
//   in_data           in   stream word (edge weight)
//   in_ready          out  loader accepts a word this cycle
//   mem_address       out  {to_node, from_node}
//   mem_write_enable  out  write strobe to the edge cache
//   mem_write_data    out  weight to write
//   add_sel           out  loader owns the edge cache address
//   busy              out  load in progress
//   done              out  one-cycle pulse with the final write
//   error             out  one-cycle pulse after a rejected start
// -----------------------------------------------------------------------------
module edge_loader
    import edge_loader_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [INDEX_WIDTH:0]     num_nodes,
    input  logic                     in_valid,
    input  logic [VALUE_WIDTH-1:0]   in_data,
    output logic                     in_ready,
    output logic [2*INDEX_WIDTH-1:0] mem_address,
    output logic                     mem_write_enable,
    output logic [VALUE_WIDTH-1:0]   mem_write_data,
    output logic                     add_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam logic [INDEX_WIDTH:0] NODE_LIMIT = (INDEX_WIDTH+1)'(MAX_NODES);

    loader_state_t          state;
    loader_state_t          state_next;
    logic [INDEX_WIDTH:0]   n_latched;
    logic [INDEX_WIDTH-1:0] row;
    logic [INDEX_WIDTH-1:0] col;
    logic                   last;
    logic                   count_ok;
    logic                   accept;
    logic                   reject;
    logic                   commit;

    assign count_ok = (num_nodes != '0) && (num_nodes <= NODE_LIMIT);

    edge_index_counter #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_index (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .advance (commit),
        .n       (n_latched),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        commit     = 1'b0;
        case (state)
            LOADER_IDLE: begin
                if (start) begin
                    if (count_ok) begin
                        accept     = 1'b1;
                        state_next = LOADER_LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            LOADER_LOAD: begin
                // abort wins over a coincident beat: that word is dropped.
                if (abort) begin
                    state_next = LOADER_IDLE;
                end else if (in_valid) begin
                    commit = 1'b1;
                    if (last) begin
                        state_next = LOADER_IDLE;
                    end
                end
            end
            default: state_next = LOADER_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= LOADER_IDLE;
            n_latched        <= '0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            state            <= state_next;
            mem_write_enable <= commit;
            done             <= commit & last;
            error            <= reject;
            if (accept) begin
                n_latched <= num_nodes;
            end
            // Address and data hold their last written values between strobes.
            if (commit) begin
                mem_address    <= {col, row};
                mem_write_data <= in_data;
            end
        end
    end

    assign in_ready = (state == LOADER_LOAD);
    assign busy     = (state == LOADER_LOAD);
    // Keeps the loader address selected through the final strobe, which
    // lands in the cycle busy has already dropped.
    assign add_sel  = busy | mem_write_enable;

endmodule
